// File: rtl/pic16f84_pc_unit.sv
// rtl/pic16f84_pc_unit.sv - PIC16F84 Q-phase sequencer, program counter and 8-level return stack
// Controls are sampled only at the Q4 commit edge; the PC then holds steady for a whole instruction cycle.
module pic16f84_pc_unit #(
   parameter int                    PC_WIDTH     = 13,
   parameter int                    STACK_DEPTH  = 8,
   parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
   localparam int                   SP_W         = $clog2(STACK_DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                run,
   input  logic                goto_en,
   input  logic                call_en,
   input  logic                ret_en,
   input  logic                skip_en,
   input  logic                pcl_we,
   input  logic [10:0]         target,
   input  logic [7:0]          pcl_data,
   input  logic [4:0]          pclath,
   output logic                q1,
   output logic                q2,
   output logic                q3,
   output logic                q4,
   output logic [PC_WIDTH-1:0] pc_out,
   output logic                fetch_valid,
   output logic [SP_W-1:0]     stack_ptr
);

   typedef enum logic [3:0] {
      PH_Q1 = 4'b0001,
      PH_Q2 = 4'b0010,
      PH_Q3 = 4'b0100,
      PH_Q4 = 4'b1000
   } phase_t;

   phase_t              phase_q, phase_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                fv_q, fv_d;
   logic [SP_W-1:0]     sp_q, sp_d;
   logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
   logic                push_en;
   logic [PC_WIDTH-1:0] pc_inc;
   logic [SP_W-1:0]     sp_dec;
   logic [PC_WIDTH-1:0] jump_pc;
   logic [PC_WIDTH-1:0] pcl_pc;

   assign pc_inc  = pc_q + 1'b1;
   assign sp_dec  = sp_q - 1'b1;
   assign jump_pc = PC_WIDTH'({pclath[4:3], target});
   assign pcl_pc  = PC_WIDTH'({pclath, pcl_data});

   always_comb begin
      phase_d = phase_q;
      pc_d    = pc_q;
      fv_d    = fv_q;
      sp_d    = sp_q;
      push_en = 1'b0;
      if (run) begin
         unique case (phase_q)
            PH_Q1:   phase_d = PH_Q2;
            PH_Q2:   phase_d = PH_Q3;
            PH_Q3:   phase_d = PH_Q4;
            PH_Q4: begin
               phase_d = PH_Q1;
               // A flushed (NOP) slot cannot branch, so its controls are discarded.
               if (!fv_q) begin
                  pc_d = pc_inc;
                  fv_d = 1'b1;
               end else if (ret_en) begin
                  pc_d = stack_q[sp_dec];
                  sp_d = sp_dec;
                  fv_d = 1'b0;
               end else if (call_en) begin
                  push_en = 1'b1;
                  sp_d    = sp_q + 1'b1;
                  pc_d    = jump_pc;
                  fv_d    = 1'b0;
               end else if (goto_en) begin
                  pc_d = jump_pc;
                  fv_d = 1'b0;
               end else if (pcl_we) begin
                  pc_d = pcl_pc;
                  fv_d = 1'b0;
               end else if (skip_en) begin
                  pc_d = pc_inc;
                  fv_d = 1'b0;
               end else begin
                  pc_d = pc_inc;
                  fv_d = 1'b1;
               end
            end
            default: phase_d = PH_Q1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_q <= PH_Q1;
         pc_q    <= RESET_VECTOR;
         fv_q    <= 1'b0;
         sp_q    <= '0;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_q[i] <= '0;
         end
      end else begin
         phase_q <= phase_d;
         pc_q    <= pc_d;
         fv_q    <= fv_d;
         sp_q    <= sp_d;
         // pc_q already points past the CALL, so it is the return address.
         if (push_en) begin
            stack_q[sp_q] <= pc_q;
         end
      end
   end

   assign q1          = phase_q[0];
   assign q2          = phase_q[1];
   assign q3          = phase_q[2];
   assign q4          = phase_q[3];
   assign pc_out      = pc_q;
   assign fetch_valid = fv_q;
   assign stack_ptr   = sp_q;

endmodule

// File: tb/tb_pic16f84_pc_unit.sv
// tb/tb_pic16f84_pc_unit.sv - directed scoreboard bench for pic16f84_pc_unit
module tb_pic16f84_pc_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b1;
   logic        goto_en = 1'b0, call_en = 1'b0, ret_en = 1'b0, skip_en = 1'b0, pcl_we = 1'b0;
   logic [10:0] target = '0;
   logic [7:0]  pcl_data = '0;
   logic [4:0]  pclath = '0;
   logic        q1, q2, q3, q4;
   logic [12:0] pc_out;
   logic        fetch_valid;
   logic [2:0]  stack_ptr;

   pic16f84_pc_unit dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .goto_en(goto_en), .call_en(call_en), .ret_en(ret_en), .skip_en(skip_en), .pcl_we(pcl_we),
      .target(target), .pcl_data(pcl_data), .pclath(pclath),
      .q1(q1), .q2(q2), .q3(q3), .q4(q4),
      .pc_out(pc_out), .fetch_valid(fetch_valid), .stack_ptr(stack_ptr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [12:0] pc;
      logic        fv;
      logic [2:0]  sp;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [12:0] m_pc;
   logic        m_fv;
   logic [2:0]  m_sp;
   logic [12:0] m_stk [8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 13'h0000;
      m_fv = 1'b0;
      m_sp = 3'd0;
      for (int i = 0; i < 8; i++) m_stk[i] = 13'h0000;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      chk("rst_q1", q1, 1);
      chk("rst_q234", {q2, q3, q4}, 0);
      chk("rst_pc", pc_out, 13'h0000);
      chk("rst_fv", fetch_valid, 0);
      chk("rst_sp", stack_ptr, 0);
   endtask

   // One instruction cycle: drive controls in Q4, predict, commit, then pop and compare.
   task automatic instr(input string tag, input logic g, input logic c, input logic r,
                        input logic s, input logic p, input logic [10:0] t,
                        input logic [7:0] pd, input logic [4:0] pl);
      int   n = 0;
      exp_t e;
      @(negedge clk);
      while (q4 !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (n >= 8) chk({tag, "_q4_timeout"}, 0, 1);
      goto_en = g; call_en = c; ret_en = r; skip_en = s; pcl_we = p;
      target = t; pcl_data = pd; pclath = pl;
      if (!m_fv) begin
         m_pc = m_pc + 13'd1; m_fv = 1'b1;
      end else if (r) begin
         m_sp = m_sp - 3'd1; m_pc = m_stk[m_sp]; m_fv = 1'b0;
      end else if (c) begin
         m_stk[m_sp] = m_pc; m_sp = m_sp + 3'd1; m_pc = {pl[4:3], t}; m_fv = 1'b0;
      end else if (g) begin
         m_pc = {pl[4:3], t}; m_fv = 1'b0;
      end else if (p) begin
         m_pc = {pl, pd}; m_fv = 1'b0;
      end else if (s) begin
         m_pc = m_pc + 13'd1; m_fv = 1'b0;
      end else begin
         m_pc = m_pc + 13'd1; m_fv = 1'b1;
      end
      sb.push_back('{pc: m_pc, fv: m_fv, sp: m_sp});
      @(posedge clk);
      #1;
      goto_en = 0; call_en = 0; ret_en = 0; skip_en = 0; pcl_we = 0;
      e = sb.pop_front();
      chk({tag, "_q1"}, q1, 1);
      chk({tag, "_pc"}, pc_out, e.pc);
      chk({tag, "_fv"}, fetch_valid, e.fv);
      chk({tag, "_sp"}, stack_ptr, e.sp);
   endtask

   task automatic idle(input string tag);
      instr(tag, 0, 0, 0, 0, 0, 11'h0, 8'h0, 5'h0);
   endtask

   logic [12:0] frozen_pc;

   initial begin
      // T1 reset and first fetch
      do_reset();
      idle("t1_first");
      chk("t1_pc1", pc_out, 13'h0001);
      chk("t1_fv1", fetch_valid, 1);

      // T2 increment wrap at 0x1FFF
      instr("t2_pcl", 0, 0, 0, 0, 1, 11'h0, 8'hFE, 5'h1F);
      idle("t2_nop");
      chk("t2_top", pc_out, 13'h1FFF);
      idle("t2_wrap");
      chk("t2_zero", pc_out, 13'h0000);

      // T3 goto with PCLATH page bits
      instr("t3_goto", 1, 0, 0, 0, 0, 11'h123, 8'h0, 5'b11000);
      chk("t3_pc", pc_out, 13'h1923);
      idle("t3_next");
      chk("t3_pc_next", pc_out, 13'h1924);

      // T4 call and return
      instr("t4_pcl", 0, 0, 0, 0, 1, 11'h0, 8'h3F, 5'h00);
      idle("t4_nop");
      instr("t4_call", 0, 1, 0, 0, 0, 11'h200, 8'h0, 5'h00);
      chk("t4_sp1", stack_ptr, 1);
      idle("t4_nop2");
      instr("t4_ret", 0, 0, 1, 0, 0, 11'h0, 8'h0, 5'h00);
      chk("t4_retpc", pc_out, 13'h0040);
      idle("t4_nop3");

      // T5 nine nested calls overwrite entry 0
      for (int i = 0; i < 9; i++) begin
         instr("t5_call", 0, 1, 0, 0, 0, 11'h100 + 11'(i * 32), 8'h0, 5'h00);
         idle("t5_nop");
      end
      for (int i = 0; i < 9; i++) begin
         instr("t5_ret", 0, 0, 1, 0, 0, 11'h0, 8'h0, 5'h00);
         if (i == 0) chk("t5_ret1", pc_out, 13'h01E1);
         if (i == 8) chk("t5_ret9", pc_out, 13'h01E1);
         idle("t5_nop");
      end
      chk("t5_sp", stack_ptr, 0);

      // T6 run freeze mid-Q2, with a stray goto that must be ignored
      @(posedge clk); #1;
      chk("t6_inq2", q2, 1);
      run = 1'b0;
      goto_en = 1'b1;
      target = 11'h7FF;
      frozen_pc = m_pc;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("t6_frz_q2", q2, 1);
         chk("t6_frz_pc", pc_out, frozen_pc);
      end
      run = 1'b1;
      @(posedge clk); #1;
      goto_en = 1'b0;
      chk("t6_resume_q3", q3, 1);
      idle("t6_after_frz");

      // priority: ret beats call and skip, no push
      instr("t6_call", 0, 1, 0, 0, 0, 11'h055, 8'h0, 5'h00);
      idle("t6_nop");
      instr("t6_prio", 0, 1, 1, 1, 0, 11'h0AA, 8'h0, 5'h00);
      chk("t6_prio_sp", stack_ptr, 0);
      idle("t6_nop2");
      instr("t6_skip", 0, 0, 0, 1, 0, 11'h0, 8'h0, 5'h00);
      // controls in a flushed slot are ignored
      instr("t6_ign", 1, 0, 0, 0, 0, 11'h3FF, 8'h0, 5'h18);

      // reset mid-cycle, then pop from empty
      @(negedge clk);
      while (q3 !== 1'b1) @(negedge clk);
      do_reset();
      idle("t7_nop");
      instr("t7_pop_empty", 0, 0, 1, 0, 0, 11'h0, 8'h0, 5'h00);
      chk("t7_sp7", stack_ptr, 7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
